// File: rtl/matvec_mac_sequencer.sv
// Streams a vector, then a matrix column by column, through one shared 32x32 multiplier
// and accumulator. Define MATVEC_BIAS_EN to add a per-column bias word (LOAD_BIAS state).
module matvec_mac_sequencer #(
    parameter int VEC_LEN = 3,
    parameter int OUT_LEN = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [31:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [31:0]         out_data,
    output logic [$clog2(OUT_LEN)-1:0] out_idx,
    output logic                       done
);
    localparam int ROW_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int COL_W = $clog2(OUT_LEN);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VEC_LEN - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_LEN - 1);

`ifdef MATVEC_BIAS_EN
    typedef enum logic [2:0] {IDLE, LOAD_VEC, LOAD_BIAS, ACC, EMIT} state_t;
    localparam state_t COL_START = LOAD_BIAS;
`else
    typedef enum logic [2:0] {IDLE, LOAD_VEC, ACC, EMIT} state_t;
    localparam state_t COL_START = ACC;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [31:0]       r_vec [VEC_LEN];
    logic signed [31:0]       r_acc;
    logic [ROW_W-1:0]         r_row;
    logic [COL_W-1:0]         r_col;
    logic                     r_done;
    logic                     w_in_fire;
    logic                     w_last_row;

    function automatic logic signed [31:0] mul_lo32(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        logic signed [63:0] p;
        p = a * b;
        return p[31:0];
    endfunction

    function automatic logic signed [31:0] add_wrap(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        return a + b;
    endfunction

    assign w_in_fire  = in_valid && in_ready;
    assign w_last_row = (r_row == LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = LOAD_VEC;
            end
            LOAD_VEC: begin
                in_ready = 1'b1;
                if (w_in_fire && w_last_row) w_state_nxt = COL_START;
            end
`ifdef MATVEC_BIAS_EN
            LOAD_BIAS: begin
                in_ready = 1'b1;
                if (w_in_fire) w_state_nxt = ACC;
            end
`endif
            ACC: begin
                in_ready = 1'b1;
                if (w_in_fire && w_last_row) w_state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = (r_col == LAST_COL) ? IDLE : COL_START;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) r_vec[i] <= '0;
        end else begin
            r_done <= (r_state == EMIT) && out_ready && (r_col == LAST_COL);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                LOAD_VEC: begin
                    if (w_in_fire) begin
                        r_vec[r_row] <= in_data;
                        r_row        <= w_last_row ? '0 : r_row + 1'b1;
`ifndef MATVEC_BIAS_EN
                        if (w_last_row) r_acc <= '0;
`endif
                    end
                end
`ifdef MATVEC_BIAS_EN
                LOAD_BIAS: begin
                    if (w_in_fire) r_acc <= in_data;
                end
`endif
                ACC: begin
                    if (w_in_fire) begin
                        r_acc <= add_wrap(r_acc, mul_lo32(in_data, r_vec[r_row]));
                        r_row <= w_last_row ? '0 : r_row + 1'b1;
                    end
                end
                EMIT: begin
                    // out_data is the accumulator itself, so it only moves after the handshake
                    if (out_ready) begin
                        r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
`ifndef MATVEC_BIAS_EN
                        r_acc <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_acc;
    assign out_idx  = r_col;
    assign done     = r_done;
endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// Self-checking bench for matvec_mac_sequencer: table-driven jobs, hand-written corner
// sequences (stall, extra start, mid-job reset) and randomized jobs against a reference model.
module tb_matvec_mac_sequencer;
    localparam int VL = 3;
    localparam int OL = 5;
`ifdef MATVEC_BIAS_EN
    localparam bit BIAS = 1'b1;
`else
    localparam bit BIAS = 1'b0;
`endif

    typedef struct packed {
        logic [VL-1:0][31:0]         vec;
        logic [VL-1:0][OL-1:0][31:0] mat;
        logic [OL-1:0][31:0]         bias;
        logic [OL-1:0][31:0]         res;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        done;

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;

    job_t tbl [3];

    matvec_mac_sequencer #(.VEC_LEN(VL), .OUT_LEN(OL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready) consumed <= consumed + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input logic [31:0] req, input int idx, input int stall, input bit last);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("out_data", out_data, req);
        chk("out_idx", 32'(out_idx), 32'(idx));
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 32'hDEAD0000 + 32'(k);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, req);
            chk("hold_idx", 32'(out_idx), 32'(idx));
            chk("emit_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("done", 32'(done), 32'(last));
        chk("busy_after_emit", 32'(busy), 32'(!last));
        if (last) begin
            @(negedge clk);
            chk("done_one_pulse", 32'(done), 32'd0);
        end
    endtask

    task automatic run_job(input job_t jb, input int stall_col, input int stall_n, input bit extra_start);
        int c0;
        c0    = consumed;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < VL; i++) begin
            push(jb.vec[i]);
            if (extra_start && i == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_extra_start", 32'(busy), 32'd1);
            end
        end
        for (int j = 0; j < OL; j++) begin
            if (BIAS) push(jb.bias[j]);
            for (int i = 0; i < VL; i++) push(jb.mat[i][j]);
            collect(jb.res[j], j, (j == stall_col) ? stall_n : 0, j == OL - 1);
        end
        chk("words_consumed", 32'(consumed - c0), 32'(VL + OL * (VL + int'(BIAS))));
    endtask

    function automatic job_t model(input job_t jb);
        job_t r;
        logic [31:0] acc;
        r = jb;
        for (int j = 0; j < OL; j++) begin
            acc = BIAS ? jb.bias[j] : 32'd0;
            for (int i = 0; i < VL; i++) acc = acc + jb.vec[i] * jb.mat[i][j];
            r.res[j] = acc;
        end
        return r;
    endfunction

    initial begin
        int   c0;
        job_t jb;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        c0 = consumed;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("idle_no_consume", 32'(consumed - c0), 32'd0);

        tbl[0] = '0;
        for (int i = 0; i < VL; i++) tbl[0].vec[i] = 32'(i + 1);
        for (int i = 0; i < VL; i++) for (int j = 0; j < OL; j++) tbl[0].mat[i][j] = 32'd1;
        for (int j = 0; j < OL; j++) tbl[0].bias[j] = 32'(j);
        tbl[0].res = BIAS ? {32'd10, 32'd9, 32'd8, 32'd7, 32'd6} : {5{32'd6}};

        tbl[1] = '0;
        tbl[1].vec[0]    = 32'd2;
        tbl[1].mat[0][0] = 32'h7FFFFFFF;
        tbl[1].res       = {32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFE};

        tbl[2] = '0;
        tbl[2].vec = {32'd0, 32'd5, 32'hFFFFFFFF};
        for (int i = 0; i < VL; i++) for (int j = 0; j < OL; j++) tbl[2].mat[i][j] = 32'(j - i);
        for (int j = 0; j < OL; j++) tbl[2].bias[j] = 32'd10;
        tbl[2].res = BIAS ? {32'd21, 32'd17, 32'd13, 32'd9, 32'd5}
                          : {32'd11, 32'd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFB};

        for (int t = 0; t < 3; t++) run_job(tbl[t], -1, 0, 1'b0);

        // backpressure at column 2 with in_valid held high during EMIT
        run_job(tbl[0], 2, 4, 1'b0);
        // second start while loading the vector
        run_job(tbl[0], -1, 0, 1'b1);

        // reset in the middle of column 1 accumulation
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < VL; i++) push(tbl[0].vec[i]);
        if (BIAS) push(tbl[0].bias[0]);
        for (int i = 0; i < VL; i++) push(tbl[0].mat[i][0]);
        collect(tbl[0].res[0], 0, 0, 1'b0);
        if (BIAS) push(tbl[0].bias[1]);
        push(tbl[0].mat[0][1]);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        run_job(tbl[0], -1, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            jb = '0;
            for (int i = 0; i < VL; i++) jb.vec[i] = (r < 4) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            for (int i = 0; i < VL; i++) for (int j = 0; j < OL; j++) jb.mat[i][j] = $urandom;
            for (int j = 0; j < OL; j++) jb.bias[j] = $urandom;
            jb = model(jb);
            run_job(jb, int'($urandom_range(0, OL - 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
